// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the MEM/WB stage: datapath width and write-back source selects.
package mem_wb_stage_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    WB_SEL_ALU = 2'b00,
    WB_SEL_MEM = 2'b01,
    WB_SEL_PC4 = 2'b10,
    WB_SEL_RSV = 2'b11
  } wb_sel_e;

endpackage

// File: rtl/mem_wb_stage_perf_counters.sv
// Free-running cycle, memory-stall and retired-instruction counters.
// All three wrap modulo 2^CNT_WIDTH; reset beats every increment.
module perf_counters #(
  parameter int CNT_WIDTH = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 stall_i,
  input  logic                 retire_i,
  output logic [CNT_WIDTH-1:0] cycle_o,
  output logic [CNT_WIDTH-1:0] stall_o,
  output logic [CNT_WIDTH-1:0] instret_o
);

  localparam logic [CNT_WIDTH-1:0] ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [CNT_WIDTH-1:0] cycle_q, cycle_d;
  logic [CNT_WIDTH-1:0] stall_q, stall_d;
  logic [CNT_WIDTH-1:0] instret_q, instret_d;

  always_comb begin
    cycle_d   = cycle_q + ONE;
    stall_d   = stall_i  ? stall_q + ONE   : stall_q;
    instret_d = retire_i ? instret_q + ONE : instret_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cycle_q   <= '0;
      stall_q   <= '0;
      instret_q <= '0;
    end else begin
      cycle_q   <= cycle_d;
      stall_q   <= stall_d;
      instret_q <= instret_d;
    end
  end

  assign cycle_o   = cycle_q;
  assign stall_o   = stall_q;
  assign instret_o = instret_q;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with write-back source select and performance counters.
// Frozen (no bubble) while MEM_BUSYWAIT is high so WB_DATA stays stable for store forwarding.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int XLEN      = mem_wb_stage_pkg::XLEN,
  parameter int CNT_WIDTH = 64
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 MEM_BUSYWAIT,
  input  logic                 VALID_MEM,
  input  logic                 REG_WRITE_EN_MEM,
  input  logic [1:0]           WB_VALUE_SEL_MEM,
  input  logic                 MEM_READ_EN_MEM,
  input  logic [XLEN-1:0]      PC_4_MEM,
  input  logic [XLEN-1:0]      ALU_RESULT,
  input  logic [XLEN-1:0]      READ_DATA,
  input  logic [4:0]           REG_WRITE_ADDR_MEM,
  output logic                 VALID_WB,
  output logic                 REG_WRITE_EN_WB,
  output logic [4:0]           REG_WRITE_ADDR_WB,
  output logic [XLEN-1:0]      WB_DATA,
  output logic                 MEM_READ_EN_WB,
  output logic [CNT_WIDTH-1:0] INSTRET,
  output logic [CNT_WIDTH-1:0] CYCLE_CNT,
  output logic [CNT_WIDTH-1:0] STALL_CNT
);

  logic            valid_q, valid_d;
  logic            we_q, we_d;
  logic            mre_q, mre_d;
  logic [4:0]      rd_q, rd_d;
  wb_sel_e         sel_q, sel_d;
  logic [XLEN-1:0] pc4_q, pc4_d;
  logic [XLEN-1:0] alu_q, alu_d;
  logic [XLEN-1:0] rdata_q, rdata_d;

  // Bubbles and x0 destinations never reach the register-file write port.
  always_comb begin
    valid_d = VALID_MEM;
    we_d    = VALID_MEM & REG_WRITE_EN_MEM & (REG_WRITE_ADDR_MEM != 5'd0);
    mre_d   = VALID_MEM & MEM_READ_EN_MEM;
    rd_d    = REG_WRITE_ADDR_MEM;
    sel_d   = wb_sel_e'(WB_VALUE_SEL_MEM);
    pc4_d   = PC_4_MEM;
    alu_d   = ALU_RESULT;
    rdata_d = READ_DATA;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      valid_q <= 1'b0;
      we_q    <= 1'b0;
      mre_q   <= 1'b0;
      rd_q    <= 5'd0;
      sel_q   <= WB_SEL_ALU;
      pc4_q   <= '0;
      alu_q   <= '0;
      rdata_q <= '0;
    end else if (!MEM_BUSYWAIT) begin
      valid_q <= valid_d;
      we_q    <= we_d;
      mre_q   <= mre_d;
      rd_q    <= rd_d;
      sel_q   <= sel_d;
      pc4_q   <= pc4_d;
      alu_q   <= alu_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    WB_DATA = alu_q;
    case (sel_q)
      WB_SEL_MEM: WB_DATA = rdata_q;
      WB_SEL_PC4: WB_DATA = pc4_q;
      default:    WB_DATA = alu_q;
    endcase
  end

  assign VALID_WB          = valid_q;
  assign REG_WRITE_EN_WB   = we_q;
  assign REG_WRITE_ADDR_WB = rd_q;
  assign MEM_READ_EN_WB    = mre_q;

  perf_counters #(.CNT_WIDTH(CNT_WIDTH)) u_perf (
    .clk_i     (CLK),
    .rst_i     (RESET),
    .stall_i   (MEM_BUSYWAIT),
    .retire_i  (valid_q & ~MEM_BUSYWAIT),
    .cycle_o   (CYCLE_CNT),
    .stall_o   (STALL_CNT),
    .instret_o (INSTRET)
  );

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed scenarios plus randomized traffic against a transaction-level model.
module tb_mem_wb_stage;

  logic        clk, reset, busy, valid_mem, we_mem, mre_mem;
  logic [1:0]  sel;
  logic [31:0] pc4, alu, rdata;
  logic [4:0]  rd;

  logic        valid_wb, we_wb, mre_wb;
  logic [4:0]  rd_wb;
  logic [31:0] wb_data;
  logic [63:0] instret, cycle_cnt, stall_cnt;

  logic        s_valid_wb, s_we_wb, s_mre_wb;
  logic [4:0]  s_rd_wb;
  logic [31:0] s_wb_data;
  logic [3:0]  s_instret, s_cycle, s_stall;

  int tests_run = 0;
  int tests_failed = 0;

  // Model: the instruction currently in WB and the counters.
  logic        m_valid, m_we, m_mre;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  logic [63:0] m_cyc, m_stl, m_ret;

  mem_wb_stage dut (
    .CLK(clk), .RESET(reset), .MEM_BUSYWAIT(busy), .VALID_MEM(valid_mem),
    .REG_WRITE_EN_MEM(we_mem), .WB_VALUE_SEL_MEM(sel), .MEM_READ_EN_MEM(mre_mem),
    .PC_4_MEM(pc4), .ALU_RESULT(alu), .READ_DATA(rdata), .REG_WRITE_ADDR_MEM(rd),
    .VALID_WB(valid_wb), .REG_WRITE_EN_WB(we_wb), .REG_WRITE_ADDR_WB(rd_wb),
    .WB_DATA(wb_data), .MEM_READ_EN_WB(mre_wb), .INSTRET(instret),
    .CYCLE_CNT(cycle_cnt), .STALL_CNT(stall_cnt)
  );

  // Narrow-counter copy so wrap-around is reachable in a few cycles.
  mem_wb_stage #(.CNT_WIDTH(4)) dut_small (
    .CLK(clk), .RESET(reset), .MEM_BUSYWAIT(busy), .VALID_MEM(valid_mem),
    .REG_WRITE_EN_MEM(we_mem), .WB_VALUE_SEL_MEM(sel), .MEM_READ_EN_MEM(mre_mem),
    .PC_4_MEM(pc4), .ALU_RESULT(alu), .READ_DATA(rdata), .REG_WRITE_ADDR_MEM(rd),
    .VALID_WB(s_valid_wb), .REG_WRITE_EN_WB(s_we_wb), .REG_WRITE_ADDR_WB(s_rd_wb),
    .WB_DATA(s_wb_data), .MEM_READ_EN_WB(s_mre_wb), .INSTRET(s_instret),
    .CYCLE_CNT(s_cycle), .STALL_CNT(s_stall)
  );

  always #5 clk = ~clk;

  task automatic randomize_mem();
    valid_mem = 1'($urandom);
    we_mem    = 1'($urandom);
    mre_mem   = 1'($urandom);
    sel       = 2'($urandom);
    pc4       = $urandom;
    alu       = $urandom;
    rdata     = $urandom;
    rd        = 5'($urandom);
  endtask

  // Advance one clock edge, updating the model from the inputs presented before it.
  task automatic step();
    if (reset) begin
      m_valid = 0; m_we = 0; m_mre = 0; m_rd = 0; m_data = 0;
      m_cyc = 0; m_stl = 0; m_ret = 0;
    end else begin
      m_cyc = m_cyc + 1;
      if (busy) m_stl = m_stl + 1;
      else begin
        if (m_valid) m_ret = m_ret + 1;
        m_valid = valid_mem;
        m_we    = valid_mem && we_mem && (rd != 0);
        m_mre   = valid_mem && mre_mem;
        m_rd    = rd;
        m_data  = (sel == 2'b01) ? rdata : (sel == 2'b10) ? pc4 : alu;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    randomize_mem();
    busy = 1'($urandom);
    reset = 1;
    step();
    step();
    tests_run++;
    if ({valid_wb, we_wb, rd_wb, mre_wb, wb_data} !== 39'd0) begin
      tests_failed++;
      $display("FAIL reset_wb got %b/%b/%0d/%b/%h want all zero", valid_wb, we_wb, rd_wb, mre_wb, wb_data);
    end
    tests_run++;
    if ({instret, cycle_cnt, stall_cnt} !== 192'd0) begin
      tests_failed++;
      $display("FAIL reset_cnt got %0d/%0d/%0d want 0/0/0", instret, cycle_cnt, stall_cnt);
    end
    reset = 0;
    busy = 0;
    for (int i = 0; i < 5; i++) begin
      randomize_mem();
      step();
    end
    tests_run++;
    if (cycle_cnt !== 64'd5) begin
      tests_failed++;
      $display("FAIL reset_cycle5 got %0d want 5", cycle_cnt);
    end
    tests_run++;
    if (stall_cnt !== 64'd0) begin
      tests_failed++;
      $display("FAIL reset_stall0 got %0d want 0", stall_cnt);
    end
  endtask

  task automatic test_alu_write();
    logic [63:0] r0;
    randomize_mem();
    busy = 0; valid_mem = 1; we_mem = 1; mre_mem = 0; rd = 5; sel = 2'b00; alu = 32'h1234;
    step();
    tests_run++;
    if ({valid_wb, we_wb, rd_wb, wb_data} !== {1'b1, 1'b1, 5'd5, 32'h1234}) begin
      tests_failed++;
      $display("FAIL alu_write got v=%b we=%b rd=%0d data=%h want 1/1/5/1234", valid_wb, we_wb, rd_wb, wb_data);
    end
    r0 = m_ret;
    randomize_mem();
    step();
    tests_run++;
    if (instret !== r0 + 1) begin
      tests_failed++;
      $display("FAIL alu_instret got %0d want %0d", instret, r0 + 1);
    end
  endtask

  task automatic test_source_select();
    logic [31:0] a;
    randomize_mem();
    busy = 0; valid_mem = 1; we_mem = 1; mre_mem = 1; rd = 9; sel = 2'b01; rdata = 32'hFFFF_FF80;
    step();
    tests_run++;
    if (wb_data !== 32'hFFFF_FF80 || mre_wb !== 1'b1) begin
      tests_failed++;
      $display("FAIL sel_mem got data=%h mre=%b want ffffff80/1", wb_data, mre_wb);
    end
    randomize_mem();
    valid_mem = 1; mre_mem = 0; sel = 2'b10; pc4 = 32'h104;
    step();
    tests_run++;
    if (wb_data !== 32'h104 || mre_wb !== 1'b0) begin
      tests_failed++;
      $display("FAIL sel_pc4 got data=%h mre=%b want 104/0", wb_data, mre_wb);
    end
    randomize_mem();
    sel = 2'b11; a = $urandom; alu = a;
    step();
    tests_run++;
    if (wb_data !== a) begin
      tests_failed++;
      $display("FAIL sel_rsv got %h want %h", wb_data, a);
    end
  endtask

  task automatic test_stall_hold();
    logic [31:0] d;
    logic [63:0] s0, r0;
    randomize_mem();
    d = $urandom;
    busy = 0; valid_mem = 1; we_mem = 1; mre_mem = 1; rd = 7; sel = 2'b01; rdata = d;
    step();
    s0 = m_stl;
    r0 = m_ret;
    busy = 1;
    for (int i = 0; i < 4; i++) begin
      randomize_mem();
      step();
      tests_run++;
      if ({valid_wb, we_wb, mre_wb, rd_wb, wb_data} !== {1'b1, 1'b1, 1'b1, 5'd7, d} || instret !== r0) begin
        tests_failed++;
        $display("FAIL stall_hold%0d got v=%b we=%b mre=%b rd=%0d data=%h ir=%0d want 1/1/1/7/%h ir=%0d",
                 i, valid_wb, we_wb, mre_wb, rd_wb, wb_data, instret, d, r0);
      end
    end
    tests_run++;
    if (stall_cnt !== s0 + 4) begin
      tests_failed++;
      $display("FAIL stall_cnt got %0d want %0d", stall_cnt, s0 + 4);
    end
    busy = 0;
    randomize_mem();
    step();
    tests_run++;
    if (instret !== r0 + 1) begin
      tests_failed++;
      $display("FAIL stall_retire got %0d want %0d", instret, r0 + 1);
    end
  endtask

  task automatic test_x0_bubble();
    logic [63:0] r0;
    randomize_mem();
    busy = 0; valid_mem = 1; we_mem = 1; rd = 0;
    step();
    tests_run++;
    if (we_wb !== 1'b0 || valid_wb !== 1'b1) begin
      tests_failed++;
      $display("FAIL x0_we got we=%b v=%b want 0/1", we_wb, valid_wb);
    end
    r0 = m_ret;
    randomize_mem();
    valid_mem = 0; we_mem = 1; mre_mem = 1; rd = 12;
    step();
    tests_run++;
    if ({valid_wb, we_wb, mre_wb} !== 3'b000 || instret !== r0 + 1) begin
      tests_failed++;
      $display("FAIL bubble_cap got v=%b we=%b mre=%b ir=%0d want 0/0/0 ir=%0d", valid_wb, we_wb, mre_wb, instret, r0 + 1);
    end
    randomize_mem();
    step();
    tests_run++;
    if (instret !== r0 + 1) begin
      tests_failed++;
      $display("FAIL bubble_instret got %0d want %0d", instret, r0 + 1);
    end
  endtask

  task automatic test_reset_mid_stall();
    randomize_mem();
    busy = 0; valid_mem = 1; we_mem = 1; rd = 3;
    step();
    busy = 1;
    randomize_mem();
    step();
    step();
    reset = 1;
    step();
    tests_run++;
    if ({valid_wb, we_wb, mre_wb, wb_data} !== 35'd0 || {instret, cycle_cnt, stall_cnt} !== 192'd0) begin
      tests_failed++;
      $display("FAIL reset_stall got v=%b we=%b mre=%b data=%h ir=%0d cyc=%0d st=%0d want all zero",
               valid_wb, we_wb, mre_wb, wb_data, instret, cycle_cnt, stall_cnt);
    end
    reset = 0; busy = 0;
    randomize_mem();
    valid_mem = 1;
    step();
    tests_run++;
    if (valid_wb !== 1'b1 || instret !== 64'd0 || cycle_cnt !== 64'd1) begin
      tests_failed++;
      $display("FAIL first_after_reset got v=%b ir=%0d cyc=%0d want 1/0/1", valid_wb, instret, cycle_cnt);
    end
  endtask

  task automatic test_wrap();
    reset = 1;
    step();
    reset = 0; busy = 0;
    for (int i = 0; i < 16; i++) begin
      randomize_mem();
      valid_mem = 1;
      step();
    end
    tests_run++;
    if (s_cycle !== 4'd0 || cycle_cnt !== 64'd16 || s_instret !== 4'd15 || instret !== 64'd15) begin
      tests_failed++;
      $display("FAIL wrap_cycle got s_cyc=%0d cyc=%0d s_ir=%0d ir=%0d want 0/16/15/15", s_cycle, cycle_cnt, s_instret, instret);
    end
    randomize_mem();
    step();
    tests_run++;
    if (s_instret !== 4'd0 || instret !== 64'd16) begin
      tests_failed++;
      $display("FAIL wrap_instret got s_ir=%0d ir=%0d want 0/16", s_instret, instret);
    end
    busy = 1;
    for (int i = 0; i < 16; i++) begin
      randomize_mem();
      step();
    end
    tests_run++;
    if (s_stall !== 4'd0 || stall_cnt !== 64'd16) begin
      tests_failed++;
      $display("FAIL wrap_stall got s_st=%0d st=%0d want 0/16", s_stall, stall_cnt);
    end
    busy = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      randomize_mem();
      busy  = ($urandom_range(0, 2) == 0);
      reset = ($urandom_range(0, 39) == 0);
      step();
      tests_run++;
      if ({valid_wb, we_wb, mre_wb, rd_wb, wb_data} !== {m_valid, m_we, m_mre, m_rd, m_data}) begin
        tests_failed++;
        $display("FAIL rand_wb[%0d] got %b/%b/%b/%0d/%h want %b/%b/%b/%0d/%h", i,
                 valid_wb, we_wb, mre_wb, rd_wb, wb_data, m_valid, m_we, m_mre, m_rd, m_data);
      end
      tests_run++;
      if (instret !== m_ret || cycle_cnt !== m_cyc || stall_cnt !== m_stl ||
          s_instret !== m_ret[3:0] || s_cycle !== m_cyc[3:0] || s_stall !== m_stl[3:0]) begin
        tests_failed++;
        $display("FAIL rand_cnt[%0d] got ir=%0d cyc=%0d st=%0d small=%0d/%0d/%0d want %0d/%0d/%0d", i,
                 instret, cycle_cnt, stall_cnt, s_instret, s_cycle, s_stall, m_ret, m_cyc, m_stl);
      end
    end
    reset = 0;
  endtask

  initial begin
    clk = 0; reset = 1; busy = 0;
    valid_mem = 0; we_mem = 0; mre_mem = 0; sel = 0; pc4 = 0; alu = 0; rdata = 0; rd = 0;
    m_valid = 0; m_we = 0; m_mre = 0; m_rd = 0; m_data = 0; m_cyc = 0; m_stl = 0; m_ret = 0;
    test_reset();
    test_alu_write();
    test_source_select();
    test_stall_hold();
    test_x0_bubble();
    test_reset_mid_stall();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM/WB pipeline register plus write-back select, directly downstream of the memory stage.
- Captures the memory stage's outputs and selects the write-back value: ALU result, load data or PC+4.
- Drives the register-file write port and the WB-side forwarding signals (value, address, read-enable) back into the memory stage's store-data forwarding.
- Holds performance counters for retired instructions, total cycles and memory-stall cycles.

Parameters:
XLEN, 32, datapath width
CNT_WIDTH, 64, width of each performance counter

Ports:
CLK  input  1  clock; all state updates on rising edge
RESET  input  1  reset; synchronous, active-high
MEM_BUSYWAIT  input  1  memory stage busy; whole pipeline frozen
VALID_MEM  input  1  memory-stage slot holds a real instruction (0 = bubble)
REG_WRITE_EN_MEM  input  1  instruction writes rd
WB_VALUE_SEL_MEM  input  2  write-back source select
MEM_READ_EN_MEM  input  1  instruction is a load
PC_4_MEM  input  XLEN  PC+4 of instruction
ALU_RESULT  input  XLEN  ALU result / address
READ_DATA  input  XLEN  load data, already extended by cache
REG_WRITE_ADDR_MEM  input  5  rd
VALID_WB  output  1  WB slot holds a real instruction
REG_WRITE_EN_WB  output  1  register-file write enable
REG_WRITE_ADDR_WB  output  5  register-file write address
WB_DATA  output  XLEN  selected write-back value; also the forwarding value
MEM_READ_EN_WB  output  1  WB instruction is a load (to store-data forwarding)
INSTRET  output  CNT_WIDTH  retired-instruction count
CYCLE_CNT  output  CNT_WIDTH  cycles since reset
STALL_CNT  output  CNT_WIDTH  cycles with MEM_BUSYWAIT high

Behaviour:
- Reset (RESET=1 at edge):
  - All pipeline registers cleared to 0: VALID_WB=0, REG_WRITE_EN_WB=0, REG_WRITE_ADDR_WB=0, MEM_READ_EN_WB=0, WB_DATA=0.
  - All counters set to 0.
  - RESET has priority over everything.
- Load (MEM_BUSYWAIT=0): at the edge, every MEM-side input is captured into the WB register. One-cycle latency, MEM to WB.
- Stall (MEM_BUSYWAIT=1): WB register holds its contents unchanged; no bubble is inserted.
  - Required so that the store-data forwarding value (WB_DATA) stays stable across a multi-cycle cache access.
  - The register file rewrites the same value each stall cycle; this is idempotent.
- Bubble capture: if VALID_MEM=0, the captured REG_WRITE_EN and MEM_READ_EN are forced to 0 regardless of their input values.
- x0 suppression: REG_WRITE_EN_WB=0 whenever REG_WRITE_ADDR_WB=0, evaluated on the captured value.
- WB_DATA select (combinational from WB register fields):
  - 00 → ALU result
  - 01 → load data
  - 10 → PC+4
  - 11 → ALU result (reserved)
- WB_DATA is a function of registered values only; there is no combinational path from MEM inputs to WB outputs.
- CYCLE_CNT: +1 every non-reset edge.
- STALL_CNT: +1 on every edge where MEM_BUSYWAIT=1.
- INSTRET: +1 on an edge where VALID_WB=1 and MEM_BUSYWAIT=0 (instruction leaves WB). A stalled instruction is counted exactly once.
- All counters wrap modulo 2^CNT_WIDTH, with no saturation.
- Simultaneous events:
  - RESET with MEM_BUSYWAIT=1: reset wins.
  - First edge after reset: loads normally if MEM_BUSYWAIT=0.
- Reset mid-stall: the held instruction is discarded and not counted.

Decomposition:
- Shared package holds:
  - WB select constants: WB_SEL_ALU=2'b00, WB_SEL_MEM=2'b01, WB_SEL_PC4=2'b10.
  - XLEN.
- One natural sub-module: perf_counters (CYCLE/STALL/INSTRET with enables). The pipeline register and select mux stay inline.

Test Plan:
- Reset state: RESET=1 for 2 cycles with random inputs → all outputs 0, counters 0; after 5 free cycles CYCLE_CNT=5.
- ALU write: VALID_MEM=1, REG_WRITE_EN=1, rd=5, SEL=00, ALU_RESULT=0x1234, 1 edge → REG_WRITE_EN_WB=1, REG_WRITE_ADDR_WB=5, WB_DATA=0x1234; INSTRET=1 after the next edge.
- Source select: SEL=01 with READ_DATA=0xFFFFFF80 → WB_DATA=0xFFFFFF80, MEM_READ_EN_WB=1; SEL=10 with PC_4=0x104 → WB_DATA=0x104.
- Stall hold: load to rd=7 in WB, then MEM_BUSYWAIT=1 for 4 cycles while MEM inputs change → WB outputs constant for 4 cycles, STALL_CNT=4, INSTRET increments once, only after busywait drops.
- x0 and bubble: rd=0 with REG_WRITE_EN=1 → REG_WRITE_EN_WB=0; VALID_MEM=0 with REG_WRITE_EN=1 → REG_WRITE_EN_WB=0, VALID_WB=0, INSTRET unchanged.
- Reset mid-stall plus wrap:
  - RESET during busywait → WB cleared, INSTRET=0.
  - Counter preloaded near 2^64-1 by a bench force → wraps to 0.
